muldiv_unit: RTL
================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have a single clock and a synchronous, active-high reset. Ports: clk (input, 1, rising-edge clock) and rst (input, 1, synchronous active-high reset).
REQ-002 SHALL have port start, input, 1 bit: one-cycle request, sampled only in IDLE.
REQ-003 SHALL have port funct3, input, 3 bits: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-004 SHALL have port rd, input, 5 bits: destination register index.
REQ-005 SHALL have ports rs1_val and rs2_val, input, 32 bits each: operands taken from register-file read ports RD1/RD2.
REQ-006 SHALL have port busy, output, 1 bit: high from the cycle after acceptance until done.
REQ-007 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-008 SHALL have ports wb_we (output, 1), wb_rd (output, 5) and wb_data (output, 32): register-file write port driving we3, A3 and WD3.

Function
REQ-009 SHALL implement FSM states IDLE, CALC, FIX and DONE.
REQ-010 IDLE with start=1 SHALL capture funct3, rd, operand magnitudes and operand signs, clear the counter and go to CALC.
REQ-011 CALC SHALL run exactly 32 cycles: shift-add multiply (64-bit product) or restoring divide (1 quotient bit per cycle), then go to FIX.
REQ-012 FIX SHALL apply sign correction and select the result, then go to DONE.
REQ-013 MUL SHALL return product[31:0]; MULH/MULHSU/MULHU SHALL return product[63:32] with signed×signed, signed×unsigned and unsigned×unsigned operands respectively.
REQ-014 DIV/REM SHALL truncate toward zero, and the remainder SHALL take the dividend's sign.
REQ-015 Divide by zero SHALL give quotient 0xFFFFFFFF and remainder = rs1_val, for both signed and unsigned forms.
REQ-016 Signed overflow (0x80000000 / 0xFFFFFFFF) SHALL give quotient 0x80000000 and remainder 0.
REQ-017 Special cases SHALL keep the normal latency; only the result is overridden.
REQ-018 DONE SHALL assert done=1 for one cycle, with wb_we=1 if the captured rd≠0 (x0 writes suppressed), wb_rd=captured rd and wb_data=result, then return to IDLE.
REQ-019 Latency SHALL be start sampled at edge E0 and done high in the cycle following edge E34 (34 cycles).
REQ-020 start while busy or in DONE SHALL be ignored, with no queueing.
REQ-021 start in the same cycle as done SHALL be ignored; a new start is accepted the next cycle, in IDLE.
REQ-022 wb_data and wb_rd SHALL hold their last values outside done, while wb_we SHALL be 0 outside done.
REQ-023 rs1_val, rs2_val, funct3 and rd SHALL be don't-care after the acceptance cycle.

Reset
REQ-024 rst=1 at a clock edge SHALL force IDLE with busy=0, done=0, wb_we=0, wb_rd=0, wb_data=0 and counter=0.
REQ-025 Reset mid-operation SHALL abort the operation with no write-back, and the result SHALL be discarded.
REQ-026 rst SHALL take priority over start in the same cycle.

Configuration
REQ-027 With macro MULDIV_FAST_MUL_EN defined, multiply ops SHALL use a single-cycle combinational 33×33 signed multiplier, skip CALC (IDLE→FIX→DONE) and have done 2 cycles after E0.
REQ-028 With MULDIV_FAST_MUL_EN undefined, multiply ops SHALL use the iterative 34-cycle path.
REQ-029 Divide behaviour and latency SHALL be identical in both configurations.

Verification
REQ-030 MUL, rs1=7, rs2=-3 (0xFFFFFFFD), rd=5 -> done after 34 cycles (2 with FAST), wb_we=1, wb_rd=5, wb_data=0xFFFFFFEB.
REQ-031 MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000; MULHSU -1×0xFFFFFFFF -> 0xFFFFFFFF.
REQ-032 DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
REQ-033 DIV 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same -> 0.
REQ-034 rd=0 MUL 3×4 -> done=1, wb_we=0; second start pulsed at cycle 10 -> ignored, exactly one done.
REQ-035 rst asserted at cycle 15 of DIVU -> busy=0 and done=0 next cycle, no wb_we pulse; fresh op afterwards completes correctly.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit with register-file write-back.
// Define MULDIV_FAST_MUL_EN for a single-cycle multiplier that skips CALC.
module muldiv_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  funct3,
    input  logic [4:0]  rd,
    input  logic [31:0] rs1_val,
    input  logic [31:0] rs2_val,
    output logic        busy,
    output logic        done,
    output logic        wb_we,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t      state;
    logic [4:0]  cnt;
    logic [2:0]  op_q;
    logic [4:0]  rd_q;
    logic [31:0] hi, lo, bmag, a_raw, res;
    logic        a_neg, b_neg, dz, ovf;

    logic        s_a, s_b, accept;
    logic [31:0] amag_in, bmag_in;
    logic [32:0] msum, shifted;
    logic        ge;
    logic [31:0] dsub, quo, rem;
    logic [63:0] prod, prod_fix;
    logic        sign_x;
`ifdef MULDIV_FAST_MUL_EN
    logic [63:0] fa, fb, fast_prod;
`endif

    // Operand signedness, magnitudes and per-cycle datapath steps
    always_comb begin
        s_a = 1'b0;
        s_b = 1'b0;
        case (funct3)
            3'd1, 3'd4, 3'd6: begin s_a = 1'b1; s_b = 1'b1; end
            3'd2:             s_a = 1'b1;
            default:          ;
        endcase
        accept  = start && !done;
        amag_in = (s_a && rs1_val[31]) ? -rs1_val : rs1_val;
        bmag_in = (s_b && rs2_val[31]) ? -rs2_val : rs2_val;
        msum    = {1'b0, hi} + (lo[0] ? {1'b0, bmag} : 33'd0);
        shifted = {hi, lo[31]};
        ge      = shifted >= {1'b0, bmag};
        dsub    = shifted[31:0] - bmag;
        sign_x  = a_neg ^ b_neg;
        prod    = {hi, lo};
        prod_fix = sign_x ? -prod : prod;
        quo     = sign_x ? -lo : lo;
        rem     = a_neg ? -hi : hi;
`ifdef MULDIV_FAST_MUL_EN
        fa = {{31{s_a & rs1_val[31]}}, s_a & rs1_val[31], rs1_val};
        fb = {{31{s_b & rs2_val[31]}}, s_b & rs2_val[31], rs2_val};
        fast_prod = fa * fb;
`endif
    end

    // Control FSM, iterative datapath and registered write-back outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 5'd0;
            op_q    <= 3'd0;
            rd_q    <= 5'd0;
            hi      <= 32'd0;
            lo      <= 32'd0;
            bmag    <= 32'd0;
            a_raw   <= 32'd0;
            res     <= 32'd0;
            a_neg   <= 1'b0;
            b_neg   <= 1'b0;
            dz      <= 1'b0;
            ovf     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            wb_we   <= 1'b0;
            wb_rd   <= 5'd0;
            wb_data <= 32'd0;
        end else begin
            done  <= 1'b0;
            wb_we <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        op_q  <= funct3;
                        rd_q  <= rd;
                        cnt   <= 5'd0;
                        hi    <= 32'd0;
                        lo    <= amag_in;
                        bmag  <= bmag_in;
                        a_raw <= rs1_val;
                        a_neg <= s_a & rs1_val[31];
                        b_neg <= s_b & rs2_val[31];
                        dz    <= (rs2_val == 32'd0);
                        ovf   <= s_a && s_b &&
                                 (rs1_val == 32'h8000_0000) &&
                                 (rs2_val == 32'hFFFF_FFFF);
                        busy  <= 1'b1;
                        state <= CALC;
`ifdef MULDIV_FAST_MUL_EN
                        if (!funct3[2]) begin
                            hi    <= fast_prod[63:32];
                            lo    <= fast_prod[31:0];
                            a_neg <= 1'b0;
                            b_neg <= 1'b0;
                            state <= FIX;
                        end
`endif
                    end
                end
                CALC: begin
                    if (op_q[2]) begin
                        hi <= ge ? dsub : shifted[31:0];
                        lo <= {lo[30:0], ge};
                    end else begin
                        hi <= msum[32:1];
                        lo <= {msum[0], lo[31:1]};
                    end
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) state <= FIX;
                end
                FIX: begin
                    case (op_q)
                        3'd0:       res <= prod_fix[31:0];
                        3'd1, 3'd2,
                        3'd3:       res <= prod_fix[63:32];
                        3'd4, 3'd5: res <= dz  ? 32'hFFFF_FFFF :
                                           ovf ? 32'h8000_0000 : quo;
                        default:    res <= dz  ? a_raw :
                                           ovf ? 32'd0 : rem;
                    endcase
                    state <= DONE;
                end
                DONE: begin
                    done    <= 1'b1;
                    wb_we   <= (rd_q != 5'd0);
                    wb_rd   <= rd_q;
                    wb_data <= res;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
